// File: rtl/byte_mem_sequencer.sv
// byte_mem_sequencer
//   Shares one byte-wide RAM between the instruction-fetch port and the
//   data (load/store) port. Each access is split into single-byte RAM
//   cycles in little-endian order. Load bytes are assembled, then sign- or
//   zero-extended. Each port gets a one-cycle ack when its access completes.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack), byte address
//   if_ack/if_rdata     completion pulse, fetched word (held until next ack)
//   d_req/d_op          data request (held until d_ack), i_type op code
//   d_addr/d_wdata      data byte address, store data (low N bytes used)
//   d_ack/d_rdata       completion pulse, extended load result
//   d_err               trap flag pulsed with d_ack (MEM_RANGE_TRAP_EN only)
//   mem_en/mem_we       RAM byte strobe, write enable (qualified by mem_en)
//   mem_addr/mem_wdata  RAM byte address, write byte
//   mem_rdata           RAM read byte, valid the cycle after a read strobe
//
// Build option
//   MEM_RANGE_TRAP_EN   when defined, misaligned halfword/word accesses and
//                       accesses that run past MEM_SIZE complete at once
//                       with d_err=1 and no RAM cycles.

// One byte lane of the load assembly buffer.
module byte_mem_lane (
    input  logic       clock,
    input  logic       reset,
    input  logic       ld,
    input  logic [7:0] din,
    output logic [7:0] q
);
    always_ff @(posedge clock) begin
        if (reset)   q <= '0;
        else if (ld) q <= din;
    end
endmodule

module byte_mem_sequencer #(
    parameter int unsigned MEM_SIZE = 131072,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [4:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
`ifdef MEM_RANGE_TRAP_EN
    output logic              d_err,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam logic [4:0] OP_LB  = 5'd21;
    localparam logic [4:0] OP_LBU = 5'd22;
    localparam logic [4:0] OP_LH  = 5'd23;
    localparam logic [4:0] OP_LHU = 5'd24;
    localparam logic [4:0] OP_LW  = 5'd25;
    localparam logic [4:0] OP_SB  = 5'd26;
    localparam logic [4:0] OP_SH  = 5'd27;
    localparam logic [4:0] OP_SW  = 5'd28;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    // Latched copy of the granted request; requester inputs are free to
    // change once the grant has been taken.
    typedef struct packed {
        logic              fetch;
        logic [4:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [2:0]        n;
        logic              store;
        logic              err;
    } req_t;

    state_t           state, state_nx;
    req_t             r;
    logic [2:0]       k;
    logic             last_fetch;
    logic             grant_d, grant_f;
    logic             d_is_mem, d_store, d_trap;
    logic [2:0]       d_n;
    logic [3:0]       lane_ld;
    logic [3:0][7:0]  lane_q;
    logic [3:0][7:0]  asm_word;

    // ---------------- request decode ----------------
    always_comb begin
        d_is_mem = (d_op >= OP_LB) && (d_op <= OP_SW);
        d_store  = (d_op >= OP_SB) && (d_op <= OP_SW);
        case (d_op)
            OP_LB, OP_LBU, OP_SB: d_n = 3'd1;
            OP_LH, OP_LHU, OP_SH: d_n = 3'd2;
            OP_LW, OP_SW:         d_n = 3'd4;
            default:              d_n = 3'd0;
        endcase
    end

`ifdef MEM_RANGE_TRAP_EN
    logic [ADDR_W:0] d_last;
    logic            d_misal;
    // One extra bit so an access near the top of the address space cannot
    // wrap back under the limit.
    assign d_last  = {1'b0, d_addr} + {{(ADDR_W-2){1'b0}}, d_n - 3'd1};
    assign d_misal = ((d_n == 3'd2) && d_addr[0]) ||
                     ((d_n == 3'd4) && (d_addr[1:0] != 2'b00));
    assign d_trap  = d_is_mem && (d_misal || (d_last >= (ADDR_W+1)'(MEM_SIZE)));
`else
    assign d_trap = 1'b0;
    // MEM_SIZE has no effect without the range trap.
    if (MEM_SIZE == 0) begin : g_no_range_check
    end
`endif

    // Round-robin: on a tie, the port not granted last wins. The reset value
    // of last_fetch gives the first tie to data.
    assign grant_d = (state == IDLE) && d_req && (!if_req || last_fetch);
    assign grant_f = (state == IDLE) && if_req && !grant_d;

    // ---------------- load assembly lanes ----------------
    // The read byte for index k arrives one cycle later. In ISSUE it goes
    // to lane k-1. The last byte is taken in DRAIN.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane_ld[i] = ((state == ISSUE) && (k != 3'd0) && ((k - 3'd1) == 3'(i))) ||
                            ((state == DRAIN) && ((r.n - 3'd1) == 3'(i)));
        byte_mem_lane u_lane (
            .clock (clock),
            .reset (reset),
            .ld    (lane_ld[i]),
            .din   (mem_rdata),
            .q     (lane_q[i])
        );
        // Bypass so the byte arriving in DRAIN is included in the result
        // written on the same edge.
        assign asm_word[i] = lane_ld[i] ? mem_rdata : lane_q[i];
    end

    function automatic logic [31:0] extend(input logic [4:0] op, input logic [31:0] w);
        case (op)
            OP_LB:   extend = {{24{w[7]}}, w[7:0]};
            OP_LBU:  extend = {24'h0, w[7:0]};
            OP_LH:   extend = {{16{w[15]}}, w[15:0]};
            OP_LHU:  extend = {16'h0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // ---------------- FSM state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            r          <= '0;
            k          <= '0;
            last_fetch <= 1'b1;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_d || grant_f) begin
                        r.fetch    <= grant_f;
                        r.op       <= grant_f ? 5'd0 : d_op;
                        r.addr     <= grant_f ? if_addr : d_addr;
                        r.wdata    <= grant_f ? 32'h0 : d_wdata;
                        r.n        <= grant_f ? 3'd4 : d_n;
                        r.store    <= grant_d && d_store;
                        r.err      <= grant_d && d_trap;
                        k          <= '0;
                        last_fetch <= grant_f;
                        // Non-memory or trapped data ops finish with zero.
                        if (grant_d && (state_nx == DONE)) d_rdata <= '0;
                    end
                end
                ISSUE: begin
                    k <= k + 3'd1;
                    // Only stores leave ISSUE straight for DONE.
                    if (state_nx == DONE) d_rdata <= '0;
                end
                DRAIN: begin
                    if (r.fetch) if_rdata <= asm_word;
                    else         d_rdata  <= extend(r.op, asm_word);
                end
                default: ;
            endcase
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
`ifdef MEM_RANGE_TRAP_EN
        d_err     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (grant_d)      state_nx = (!d_is_mem || d_trap) ? DONE : ISSUE;
                else if (grant_f) state_nx = ISSUE;
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = r.addr + ADDR_W'(k);
                if (r.store) begin
                    mem_we    = 1'b1;
                    mem_wdata = r.wdata[{k[1:0], 3'b000} +: 8];
                end
                if (k == (r.n - 3'd1)) state_nx = r.store ? DONE : DRAIN;
            end
            DRAIN: state_nx = DONE;
            DONE: begin
                if_ack   = r.fetch;
                d_ack    = !r.fetch;
`ifdef MEM_RANGE_TRAP_EN
                d_err    = !r.fetch && r.err;
`endif
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_byte_mem_sequencer.sv
module tb_byte_mem_sequencer;
    localparam int unsigned MEM_SIZE = 131072;
    localparam int          ADDR_W   = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic [4:0]        d_op;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
`ifdef MEM_RANGE_TRAP_EN
    logic              d_err;
`endif
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    always #5 clock = ~clock;

    byte_mem_sequencer #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_op      (d_op),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
`ifdef MEM_RANGE_TRAP_EN
        .d_err     (d_err),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // RAM emulation (1 KiB aliased) with a preload port.
    logic [7:0] ram [0:1023];
    logic       pl_we = 1'b0;
    logic [9:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;
    always @(posedge clock) begin
        if (pl_we) ram[pl_a] <= pl_d;
        else if (mem_en && mem_we) ram[mem_addr[9:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[9:0]];
    end

    // Log of every RAM strobe.
    int unsigned en_cnt = 0;
    logic [31:0] alog [0:255];
    logic [8:0]  wlog [0:255];
    always @(posedge clock) begin
        if (mem_en) begin
            alog[en_cnt[7:0]] <= mem_addr;
            wlog[en_cnt[7:0]] <= {mem_we, mem_wdata};
            en_cnt <= en_cnt + 1;
        end
    end

    // Reference memory image, updated per completed transaction.
    logic [7:0] ref_mem [0:1023];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ai;
            ai = a + i;
            w[8*i +: 8] = ref_mem[ai[9:0]];
        end
        return w;
    endfunction

    function automatic int nbytes(input logic [4:0] op);
        case (op)
            5'd21, 5'd22, 5'd26: return 1;
            5'd23, 5'd24, 5'd27: return 2;
            5'd25, 5'd28:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [4:0] op, input logic [31:0] a);
        logic [31:0] w;
        w = ref_word(a);
        case (op)
            5'd21:   return 32'($signed(w[7:0]));
            5'd22:   return {24'h0, w[7:0]};
            5'd23:   return 32'($signed(w[15:0]));
            5'd24:   return {16'h0, w[15:0]};
            5'd25:   return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_data(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd);
        int n, lat, cyc, idx;
        bit mem, st, trap, got;
        logic [31:0] exp, ai;
        int unsigned s0;
        n    = nbytes(op);
        mem  = (n != 0);
        st   = mem && (op >= 5'd26);
        trap = 1'b0;
`ifdef MEM_RANGE_TRAP_EN
        trap = mem && (((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00)) ||
                       (64'(a) + 64'(n) - 64'd1 >= 64'(MEM_SIZE)));
`endif
        if (!mem || trap) lat = 1;
        else if (st)      lat = n + 1;
        else              lat = n + 2;
        exp = (mem && !st && !trap) ? exp_load(op, a) : 32'h0;
        @(negedge clock);
        d_req = 1'b1; d_op = op; d_addr = a; d_wdata = wd;
        s0 = en_cnt; cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            // Inputs after grant must be ignored.
            d_op = 5'($urandom); d_addr = $urandom; d_wdata = $urandom;
            if (d_ack) got = 1'b1;
        end
        chk("d_ack_seen", 32'(got), 32'd1);
        chk("d_latency", cyc, lat);
        chk("d_rdata", d_rdata, exp);
        chk("if_ack_quiet", 32'(if_ack), 32'd0);
`ifdef MEM_RANGE_TRAP_EN
        chk("d_err", 32'(d_err), 32'(trap));
`endif
        d_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("d_ack_pulse", 32'(d_ack), 32'd0);
        chk("d_rdata_hold", d_rdata, exp);
        chk("mem_count", en_cnt - s0, (mem && !trap) ? n : 0);
        if (mem && !trap) begin
            for (int i = 0; i < n; i++) begin
                idx = (s0 + i) % 256;
                chk("mem_addr_seq", alog[idx], a + i);
                chk("mem_we", 32'(wlog[idx][8]), 32'(st));
                if (st) chk("mem_wdata", 32'(wlog[idx][7:0]), 32'(wd[8*i +: 8]));
            end
        end
        if (st && !trap) begin
            for (int i = 0; i < n; i++) begin
                ai = a + i;
                ref_mem[ai[9:0]] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] a);
        int cyc, idx;
        bit got;
        logic [31:0] exp;
        int unsigned s0;
        exp = ref_word(a);
        @(negedge clock);
        if_req = 1'b1; if_addr = a;
        s0 = en_cnt; cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if_addr = $urandom;
            if (if_ack) got = 1'b1;
        end
        chk("if_ack_seen", 32'(got), 32'd1);
        chk("if_latency", cyc, 6);
        chk("if_rdata", if_rdata, exp);
        chk("d_ack_quiet", 32'(d_ack), 32'd0);
        if_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("if_ack_pulse", 32'(if_ack), 32'd0);
        chk("if_mem_count", en_cnt - s0, 4);
        for (int i = 0; i < 4; i++) begin
            idx = (s0 + i) % 256;
            chk("if_addr_seq", alog[idx], a + i);
            chk("if_no_write", 32'(wlog[idx][8]), 32'd0);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_if_ack"}, 32'(if_ack), 32'd0);
        chk({tag, "_d_ack"}, 32'(d_ack), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
`ifdef MEM_RANGE_TRAP_EN
        chk({tag, "_d_err"}, 32'(d_err), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] pat, wd, exp_d, exp_f, ai;
        int dc, fc, sel;
        int ord [$];
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;

        // Preload RAM and reference image while held in reset.
        pat = 32'hDEADBEEF;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clock);
            pl_we = 1'b1;
            pl_a  = 10'(i);
            pl_d  = (i >= 256 && i < 260) ? pat[8*(i-256) +: 8] : 8'($urandom);
            ref_mem[i] = pl_d;
        end
        @(negedge clock);
        pl_we = 1'b0;
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Directed plan items.
        do_fetch(32'h100);
        chk("plan_fetch", if_rdata, 32'hDEADBEEF);
        do_data(5'd21, 32'h100, 32'h0);
        chk("plan_lb", d_rdata, 32'hFFFFFFEF);
        do_data(5'd22, 32'h100, 32'h0);
        chk("plan_lbu", d_rdata, 32'h000000EF);
        do_data(5'd23, 32'h102, 32'h0);
        chk("plan_lh", d_rdata, 32'hFFFFDEAD);
        do_data(5'd24, 32'h102, 32'h0);
        chk("plan_lhu", d_rdata, 32'h0000DEAD);
        do_data(5'd28, 32'h200, 32'h11223344);
        do_data(5'd25, 32'h200, 32'h0);
        chk("plan_lw", d_rdata, 32'h11223344);
        do_data(5'd26, 32'h204, 32'hA5A5A57E);
        do_data(5'd27, 32'h205, 32'h0000C3D2);
        do_data(5'd25, 32'h204, 32'h0);
        do_data(5'd5, 32'h204, 32'h0);
`ifndef MEM_RANGE_TRAP_EN
        do_data(5'd25, 32'hFFFFFFFE, 32'h0);
        do_data(5'd23, 32'h301, 32'h0);
`endif

        // Reset during the second ISSUE cycle of a SW.
        wd = $urandom;
        @(negedge clock);
        d_req = 1'b1; d_op = 5'd28; d_addr = 32'h280; d_wdata = wd;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("mid_sw_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1; d_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk_idle_outputs("abort");
        for (int i = 0; i < 2; i++) begin
            ai = 32'h280 + i;
            ref_mem[ai[9:0]] = wd[8*i +: 8];
        end
        reset = 1'b0;
        do_data(5'd25, 32'h280, 32'h0);

        // Both ports requesting continuously: data first, then alternate.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_d = ref_word(32'h140);
        exp_f = ref_word(32'h180);
        d_req = 1'b1; d_op = 5'd25; d_addr = 32'h140;
        if_req = 1'b1; if_addr = 32'h180;
        dc = 0; fc = 0;
        for (int c = 0; c < 100 && (dc < 3 || fc < 3); c++) begin
            @(posedge clock);
            @(negedge clock);
            if (d_ack) begin
                ord.push_back(0);
                chk("arb_d_rdata", d_rdata, exp_d);
                dc++;
                if (dc == 3) d_req = 1'b0;
            end
            if (if_ack) begin
                ord.push_back(1);
                chk("arb_if_rdata", if_rdata, exp_f);
                fc++;
                if (fc == 3) if_req = 1'b0;
            end
        end
        chk("arb_count", dc + fc, 6);
        for (int i = 0; i < 6; i++)
            chk("arb_order", (ord.size() > i) ? ord[i] : 9, i % 2);
        @(negedge clock);

`ifdef MEM_RANGE_TRAP_EN
        do_data(5'd25, 32'h201, 32'h0);
        do_data(5'd23, 32'h1FFFF, 32'h0);
        do_data(5'd21, 32'h1FFFF, 32'h0);
        do_data(5'd28, 32'h1FFFC, 32'h0BADF00D);
        do_data(5'd28, 32'h1FFFE, 32'h0BADF00D);
`endif

        // Randomized mix against the reference image.
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       do_data(5'(21 + sel), 32'($urandom_range(0, 1023)), $urandom);
            else if (sel == 8) do_fetch(32'($urandom_range(0, 1023)));
            else               do_data(5'($urandom_range(0, 20)), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
